// File: rtl/life_col_n.sv
// Parametrised Conway B3/S23 column: ROWS cells stepped together, with optional
// vertical wrap, generation/population counters, stable flag and single-step handshake.

module life_cell (
  input  logic [7:0] i_nb,
  input  logic       i_alive,
  output logic       o_next
);
  logic [3:0] w_cnt;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < 8; i++) w_cnt = w_cnt + 4'(i_nb[i]);
    o_next = (w_cnt == 4'd3) | (i_alive & (w_cnt == 4'd2));
  end
endmodule

module life_col_n #(
  parameter int ROWS  = 4,
  parameter int GEN_W = 16,
  parameter int WRAP  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ROWS-1:0]            w_col,
  input  logic [ROWS-1:0]            e_col,
  input  logic                       n,
  input  logic                       s,
  input  logic                       ne,
  input  logic                       nw,
  input  logic                       se,
  input  logic                       sw,
  input  logic                       enable,
  input  logic                       step,
  output logic                       step_done,
  input  logic                       write_enb,
  input  logic                       val,
  input  logic [$clog2(ROWS)-1:0]    row,
  input  logic                       scan,
  input  logic [ROWS-1:0]            scan_val,
  output logic [ROWS-1:0]            alive_col,
  output logic [GEN_W-1:0]           gen_count,
  output logic [$clog2(ROWS+1)-1:0]  pop_count,
  output logic                       stable
);
  localparam int PW = $clog2(ROWS+1);

  typedef enum logic [1:0] {S_IDLE, S_DONE, S_HOLD} state_t;

  logic [ROWS-1:0]  r_alive;
  logic [GEN_W-1:0] r_gen;
  logic             r_stable;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_step_acc;
  logic             w_gen;
  logic             w_row_ok;
  logic [ROWS-1:0]  w_next;
  logic [PW-1:0]    w_pop;
  logic             w_unused_nb;

  // Off-column neighbours are dead inputs in a wrapped build.
  assign w_unused_nb = ^{n, s, ne, nw, se, sw};

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam int RN = (r == 0)      ? ROWS-1 : r-1;
    localparam int RS = (r == ROWS-1) ? 0      : r+1;
    logic [2:0] w_north, w_south;

    if (WRAP == 0 && r == 0) begin : g_n_edge
      assign w_north = {nw, n, ne};
    end else begin : g_n_int
      assign w_north = {w_col[RN], r_alive[RN], e_col[RN]};
    end

    if (WRAP == 0 && r == ROWS-1) begin : g_s_edge
      assign w_south = {sw, s, se};
    end else begin : g_s_int
      assign w_south = {w_col[RS], r_alive[RS], e_col[RS]};
    end

    life_cell u_cell (
      .i_nb    ({w_north, w_south, w_col[r], e_col[r]}),
      .i_alive (r_alive[r]),
      .o_next  (w_next[r])
    );
  end

  // A step is only accepted when nothing of higher priority claims this edge.
  always_comb begin
    w_state_nxt = r_state;
    w_step_acc  = 1'b0;
    case (r_state)
      S_IDLE: if (step && !enable && !scan && !write_enb) begin
        w_step_acc  = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = step ? S_HOLD : S_IDLE;
      S_HOLD: if (!step) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_gen    = enable | w_step_acc;
  assign w_row_ok = (32'(row) < ROWS);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_alive  <= '0;
      r_gen    <= '0;
      r_stable <= 1'b0;
    end else if (scan) begin
      r_alive  <= scan_val;
      r_stable <= 1'b0;
    end else if (write_enb) begin
      if (w_row_ok) begin
        r_alive[row] <= val;
        r_stable     <= 1'b0;
      end
    end else if (w_gen) begin
      r_alive  <= w_next;
      r_gen    <= r_gen + GEN_W'(1);
      r_stable <= (w_next == r_alive);
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < ROWS; i++) w_pop = w_pop + PW'(r_alive[i]);
  end

  assign alive_col = r_alive;
  assign gen_count = r_gen;
  assign pop_count = w_pop;
  assign stable    = r_stable;
  assign step_done = (r_state == S_DONE);
endmodule
